// File: rtl/regc_frame_seq_if.sv
// Stream and frame-memory signal bundle for regc_frame_seq.
// master is the sequencer side; slave is the upstream/downstream/memory side.
interface regc_frame_seq_if #(
    parameter int DW = 16,
    parameter int AW = 7
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;
    logic          busy;
    logic          mem_write_read;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, mem_rdata,
        output in_ready, out_valid, out_data, frame_done, busy,
               mem_write_read, mem_address, mem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rdata,
        input  in_ready, out_valid, out_data, frame_done, busy,
               mem_write_read, mem_address, mem_wdata
    );
endinterface

// File: rtl/regc_frame_seq.sv
// Frame sequencer: writes FRAME_LEN input samples to the frame memory from
// address 0, then reads them back in address order onto the output stream.
module regc_frame_seq #(
    parameter int DW        = 16,
    parameter int AW        = 7,
    parameter int FRAME_LEN = 65
) (
    input logic              clk,
    input logic              reset,
    regc_frame_seq_if.master bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FILL     = 3'd1;
    localparam logic [2:0] RD_ISSUE = 3'd2;
    localparam logic [2:0] RD_WAIT  = 3'd3;
    localparam logic [2:0] RD_HOLD  = 3'd4;

    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    logic [2:0]    state;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          filling;
    logic          accept;

    // in_ready is gated by reset so no sample is consumed in the abort cycle.
    always_comb begin
        filling            = (state == IDLE) || (state == FILL);
        bus.in_ready       = filling && !reset;
        accept             = bus.in_valid && bus.in_ready;
        bus.busy           = (state != IDLE);
        bus.mem_write_read = accept;
        bus.mem_address    = filling ? wr_cnt : rd_cnt;
        bus.mem_wdata      = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_data   <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= 1'b0;
            case (state)
                // IDLE always holds wr_cnt==0, so IDLE and FILL share one write path.
                IDLE, FILL: begin
                    if (accept) begin
                        if (wr_cnt == LAST) begin
                            wr_cnt <= '0;
                            state  <= RD_ISSUE;
                        end else begin
                            wr_cnt <= wr_cnt + AW'(1);
                            state  <= FILL;
                        end
                    end
                end
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT: begin
                    bus.out_data  <= bus.mem_rdata;
                    bus.out_valid <= 1'b1;
                    state         <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (rd_cnt == LAST) begin
                            rd_cnt         <= '0;
                            bus.frame_done <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + AW'(1);
                            state  <= RD_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regc_frame_seq.sv
// Scoreboard bench for regc_frame_seq: a 65-word instance under randomized
// traffic with a FIFO reference model, plus a directed FRAME_LEN=1 instance.
module tb_regc_frame_seq;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int FL = 65;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regc_frame_seq_if #(.DW(DW), .AW(AW)) b0 ();
    regc_frame_seq_if #(.DW(DW), .AW(AW)) b1 ();

    regc_frame_seq #(.DW(DW), .AW(AW), .FRAME_LEN(FL)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    regc_frame_seq #(.DW(DW), .AW(AW), .FRAME_LEN(1))  dut1 (.clk(clk), .reset(reset), .bus(b1));

    // Single-port memories with registered data_out.
    logic [DW-1:0] mem0 [0:127];
    logic [DW-1:0] mem1 [0:127];
    always @(posedge clk) begin
        if (b0.mem_write_read) mem0[b0.mem_address] <= b0.mem_wdata;
        else                   b0.mem_rdata <= mem0[b0.mem_address];
        if (b1.mem_write_read) mem1[b1.mem_address] <= b1.mem_wdata;
        else                   b1.mem_rdata <= mem1[b1.mem_address];
    end

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a frame comes back in acceptance order; at most one frame in flight.
    logic [DW-1:0] exp_q[$];
    int      n_in = 0, n_out = 0;
    bit      draining = 0, done_exp = 0, hold_pend = 0;
    logic [DW-1:0] hold_data;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            n_in = 0; n_out = 0; draining = 0; done_exp = 0; hold_pend = 0;
        end else begin
            if (done_exp || b0.frame_done) check("frame_done", 32'(b0.frame_done), 32'(done_exp));
            if (done_exp) draining = 0;
            done_exp = 0;
            if (b0.in_valid || draining) check("in_ready", 32'(b0.in_ready), 32'(!draining));
            if (b0.mem_write_read || (b0.in_valid && !draining))
                check("mem_we", 32'(b0.mem_write_read), 32'(b0.in_valid && !draining));
            if (b0.mem_write_read) begin
                check("wr_addr", 32'(b0.mem_address), 32'(n_in));
                check("wr_data", 32'(b0.mem_wdata), 32'(b0.in_data));
            end
            if (b0.in_valid && b0.in_ready) begin
                exp_q.push_back(b0.in_data);
                n_in++;
                if (n_in == FL) begin n_in = 0; draining = 1; end
            end
            if (hold_pend) begin
                check("hold_valid", 32'(b0.out_valid), 32'd1);
                check("hold_data", 32'(b0.out_data), 32'(hold_data));
            end
            hold_pend = 0;
            if (b0.out_valid && b0.out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 32'd1, 32'd0);
                else check("out_data", 32'(b0.out_data), 32'(exp_q.pop_front()));
                n_out++;
                if (n_out == FL) begin n_out = 0; done_exp = 1; end
            end else if (b0.out_valid) begin
                hold_pend = 1;
                hold_data = b0.out_data;
            end
        end
    end

    bit rdy_rand = 0;
    initial begin
        b0.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            b0.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_words(input logic [DW-1:0] base, input int n, input int gap_pct, input bit rnd);
        bit acc;
        int cyc;
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                b0.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            b0.in_valid = 1'b1;
            b0.in_data  = rnd ? DW'($urandom) : base + DW'(i);
            acc = 0; cyc = 0;
            while (!acc && cyc < 4000) begin
                @(negedge clk); acc = b0.in_ready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) begin
                check("accept_timeout", 32'd0, 32'd1);
                b0.in_valid = 1'b0;
                return;
            end
        end
        b0.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (cyc < 4000) begin
            @(negedge clk);
            if (b0.frame_done) break;
            cyc++;
        end
        if (cyc == 4000) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        b0.in_valid = 1'b0; b0.in_data = '0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(b0.out_valid), 32'd0);
        check("rst_frame_done", 32'(b0.frame_done), 32'd0);
        check("rst_busy", 32'(b0.busy), 32'd0);
        check("rst_in_ready", 32'(b0.in_ready), 32'd1);
        check("rst_mem_we", 32'(b0.mem_write_read), 32'd0);
        check("rst_out_data", 32'(b0.out_data), 32'd0);
        @(posedge clk); #1;

        // Full frame, no stalls, plus first-read latency.
        send_words(16'h0000, FL, 0, 0);
        @(negedge clk); check("lat_c1", 32'(b0.out_valid), 32'd0);
        @(negedge clk); check("lat_c2", 32'(b0.out_valid), 32'd0);
        @(negedge clk); check("lat_c3", 32'(b0.out_valid), 32'd1);
        check("lat_busy", 32'(b0.busy), 32'd1);
        wait_done();

        // Random gaps on both streams.
        rdy_rand = 1;
        send_words(16'h2000, FL, 50, 0);
        wait_done();
        send_words(16'h0000, FL, 50, 1);
        wait_done();

        // Reset mid-fill, then a clean frame.
        rdy_rand = 0;
        send_words(16'h5000, 30, 0, 0);
        pulse_reset();
        @(negedge clk);
        check("abort_busy", 32'(b0.busy), 32'd0);
        check("abort_out_valid", 32'(b0.out_valid), 32'd0);
        @(posedge clk); #1;
        send_words(16'h1000, FL, 0, 0);
        wait_done();

        // Reset mid-drain.
        rdy_rand = 1;
        send_words(16'h6000, FL, 0, 0);
        repeat (20) @(posedge clk);
        #1;
        pulse_reset();
        @(negedge clk);
        check("abort2_out_valid", 32'(b0.out_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back: second frame's in_valid held through the first drain.
        send_words(16'h3000, FL, 0, 0);
        send_words(16'h3100, FL, 0, 0);
        wait_done();
        rdy_rand = 0;
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // FRAME_LEN=1 instance.
        b1.in_valid = 1'b1; b1.in_data = 16'hBEEF; b1.out_ready = 1'b1;
        @(negedge clk);
        check("f1_in_ready", 32'(b1.in_ready), 32'd1);
        check("f1_wr_addr", 32'(b1.mem_address), 32'd0);
        check("f1_we", 32'(b1.mem_write_read), 32'd1);
        @(posedge clk); #1 b1.in_valid = 1'b0;
        @(negedge clk);
        check("f1_c1_valid", 32'(b1.out_valid), 32'd0);
        check("f1_c1_busy", 32'(b1.busy), 32'd1);
        check("f1_c1_in_ready", 32'(b1.in_ready), 32'd0);
        @(negedge clk); check("f1_c2_valid", 32'(b1.out_valid), 32'd0);
        @(negedge clk);
        check("f1_c3_valid", 32'(b1.out_valid), 32'd1);
        check("f1_data", 32'(b1.out_data), 32'h0000BEEF);
        @(negedge clk);
        check("f1_done", 32'(b1.frame_done), 32'd1);
        check("f1_idle_busy", 32'(b1.busy), 32'd0);
        check("f1_idle_valid", 32'(b1.out_valid), 32'd0);
        check("f1_idle_ready", 32'(b1.in_ready), 32'd1);
        @(negedge clk);
        check("f1_done_once", 32'(b1.frame_done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
